// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-receiver handshake, payload output stream and status bundle for uart_rx_frame_ctrl.
interface uart_rx_frame_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [7:0]  out_cmd;
    logic [7:0]  out_len;
    logic        err_chk;
    logic        err_len;
    logic        err_timeout;
    logic [15:0] frame_cnt;

    // Environment side: feeds bytes in, consumes payload beats.
    modport master (
        output rx_data, rx_data_valid, out_ready,
        input  rx_data_ready, out_valid, out_data, out_last, out_cmd, out_len,
               err_chk, err_len, err_timeout, frame_cnt
    );

    // Controller side.
    modport slave (
        input  rx_data, rx_data_valid, out_ready,
        output rx_data_ready, out_valid, out_data, out_last, out_cmd, out_len,
               err_chk, err_len, err_timeout, frame_cnt
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind a UART byte receiver: SOF, CMD, LEN, PAYLOAD[LEN], CHK.
// Good frames are buffered and replayed as a valid/ready stream; bad frames pulse an error.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = 20000
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_frame_ctrl_if.slave   bus
);
    localparam int          IDXW     = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  MAX_LEN8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PLD, S_CHK, S_OUT} state_t;

    state_t          r_state;
    logic [7:0]      r_buf [MAX_LEN];
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] r_rd;
    logic [7:0]      r_cmd;
    logic [7:0]      r_len;
    logic [7:0]      r_chk;
    logic [15:0]     r_tmo;
    logic            r_rx_ready;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic [7:0]      r_out_cmd;
    logic [7:0]      r_out_len;
    logic            r_err_chk;
    logic            r_err_len;
    logic            r_err_tmo;
    logic [15:0]     r_frame_cnt;

    logic            w_acc;
    logic [IDXW-1:0] w_rd_nxt;
    logic [7:0]      w_chk_nxt;

    assign w_acc     = bus.rx_data_valid & r_rx_ready;
    assign w_rd_nxt  = r_rd + IDXW'(1);
    assign w_chk_nxt = r_chk ^ bus.rx_data;

    assign bus.rx_data_ready = r_rx_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_last      = r_out_last;
    assign bus.out_cmd       = r_out_cmd;
    assign bus.out_len       = r_out_len;
    assign bus.err_chk       = r_err_chk;
    assign bus.err_len       = r_err_len;
    assign bus.err_timeout   = r_err_tmo;
    assign bus.frame_cnt     = r_frame_cnt;

    // Payload buffer write; contents need no reset since only a checked frame is replayed.
    always_ff @(posedge clk) begin
        if (r_state == S_PLD && w_acc) r_buf[r_idx] <= bus.rx_data;
    end

    // Frame FSM: parse, checksum, timeout, and drain of the buffered payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rd        <= '0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_chk       <= '0;
            r_tmo       <= '0;
            r_rx_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_cmd   <= '0;
            r_out_len   <= '0;
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_tmo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_acc && bus.rx_data == SOF_BYTE) r_state <= S_CMD;
                end
                S_OUT: begin
                    r_tmo <= '0;
                    if (r_out_valid && bus.out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_out_cmd   <= '0;
                            r_out_len   <= '0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_rx_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_rd       <= w_rd_nxt;
                            r_out_data <= r_buf[w_rd_nxt];
                            r_out_last <= (8'(w_rd_nxt) == r_out_len - 8'd1);
                        end
                    end
                end
                default: begin
                    // In-frame states: an accepted byte beats a timeout in the same cycle.
                    if (w_acc) begin
                        r_tmo <= '0;
                        if (r_state == S_CMD) begin
                            r_cmd   <= bus.rx_data;
                            r_chk   <= bus.rx_data;
                            r_state <= S_LEN;
                        end else if (r_state == S_LEN) begin
                            r_len <= bus.rx_data;
                            r_chk <= w_chk_nxt;
                            r_idx <= '0;
                            if (bus.rx_data > MAX_LEN8) begin
                                r_err_len <= 1'b1;
                                r_state   <= S_IDLE;
                            end else if (bus.rx_data == 8'd0) begin
                                r_state <= S_CHK;
                            end else begin
                                r_state <= S_PLD;
                            end
                        end else if (r_state == S_PLD) begin
                            r_chk <= w_chk_nxt;
                            r_idx <= r_idx + IDXW'(1);
                            if (8'(r_idx) == r_len - 8'd1) r_state <= S_CHK;
                        end else begin
                            if (bus.rx_data == r_chk) begin
                                r_state     <= S_OUT;
                                r_rx_ready  <= 1'b0;
                                r_rd        <= '0;
                                r_out_valid <= 1'b1;
                                r_out_cmd   <= r_cmd;
                                r_out_len   <= r_len;
                                r_out_data  <= (r_len == 8'd0) ? 8'h00 : r_buf[0];
                                r_out_last  <= (r_len <= 8'd1);
                            end else begin
                                r_err_chk <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo     <= '0;
                        r_err_tmo <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; inputs driven and outputs sampled on negedge.
module tb_uart_rx_frame_ctrl;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; byte is accepted on the following posedge.
    task automatic send(input logic [7:0] b);
        check("rx_ready_before_send", {15'd0, bus.rx_data_ready}, 16'd1);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
    endtask

    task automatic errs_zero(input string tag);
        check(tag, {13'd0, bus.err_chk, bus.err_len, bus.err_timeout}, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_data_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rx_ready", {15'd0, bus.rx_data_ready}, 16'd1);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_frame_cnt", bus.frame_cnt, 16'd0);
        errs_zero("rst_errs");

        // 1: good 3-byte frame, back-to-back drain
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h13);
        check("t1_valid", {15'd0, bus.out_valid}, 16'd1);
        check("t1_rx_ready", {15'd0, bus.rx_data_ready}, 16'd0);
        check("t1_cmd", {8'd0, bus.out_cmd}, 16'h10);
        check("t1_len", {8'd0, bus.out_len}, 16'h03);
        check("t1_b0", {7'd0, bus.out_last, bus.out_data}, 16'h011);
        @(negedge clk);
        check("t1_b1", {7'd0, bus.out_last, bus.out_data}, 16'h022);
        @(negedge clk);
        check("t1_b2", {7'd0, bus.out_last, bus.out_data}, 16'h133);
        errs_zero("t1_errs");
        @(negedge clk);
        check("t1_done_valid", {15'd0, bus.out_valid}, 16'd0);
        check("t1_frame_cnt", bus.frame_cnt, 16'd1);
        check("t1_rx_ready_back", {15'd0, bus.rx_data_ready}, 16'd1);

        // 2: bad checksum
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h14);
        check("t2_err_chk", {13'd0, bus.err_chk, bus.err_len, bus.err_timeout}, 16'b100);
        check("t2_valid", {15'd0, bus.out_valid}, 16'd0);
        @(negedge clk);
        errs_zero("t2_pulse_end");
        check("t2_frame_cnt", bus.frame_cnt, 16'd1);

        // 3: oversize LEN, then LEN==0 frame
        send(8'hA5); send(8'h01); send(8'h14);
        check("t3_err_len", {13'd0, bus.err_chk, bus.err_len, bus.err_timeout}, 16'b010);
        send(8'hA5);
        errs_zero("t3_pulse_end");
        send(8'h01); send(8'h00); send(8'h01);
        check("t3_zero_beat", {7'd0, bus.out_last, bus.out_data}, 16'h100);
        check("t3_valid", {15'd0, bus.out_valid}, 16'd1);
        check("t3_len", {8'd0, bus.out_len}, 16'h00);
        check("t3_cmd", {8'd0, bus.out_cmd}, 16'h01);
        @(negedge clk);
        check("t3_frame_cnt", bus.frame_cnt, 16'd2);

        // 4a: timeout fires exactly TMO cycles after the last accepted byte
        send(8'hA5); send(8'h20); send(8'h02); send(8'h7E);
        repeat (TMO - 1) @(negedge clk);
        errs_zero("t4_before_tmo");
        @(negedge clk);
        check("t4_err_tmo", {13'd0, bus.err_chk, bus.err_len, bus.err_timeout}, 16'b001);
        @(negedge clk);
        errs_zero("t4_pulse_end");
        check("t4_frame_cnt", bus.frame_cnt, 16'd2);

        // 4b: byte on the timeout cycle wins
        send(8'hA5); send(8'h20); send(8'h02); send(8'h7E);
        repeat (TMO - 1) @(negedge clk);
        send(8'h55);
        errs_zero("t4b_no_tmo");
        send(8'h09);
        check("t4b_b0", {7'd0, bus.out_last, bus.out_data}, 16'h07E);
        @(negedge clk);
        check("t4b_b1", {7'd0, bus.out_last, bus.out_data}, 16'h155);
        @(negedge clk);
        check("t4b_frame_cnt", bus.frame_cnt, 16'd3);

        // 5: 4-byte frame, out_ready toggled; every beat held over a stalled cycle
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h33); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h33);
        for (int i = 1; i <= 4; i++) begin
            check("t5_beat", {6'd0, bus.out_valid, bus.out_last, bus.out_data},
                  {6'd0, 1'b1, (i == 4), 8'(i)});
            check("t5_rx_ready", {15'd0, bus.rx_data_ready}, 16'd0);
            bus.out_ready = 1'b0;
            @(negedge clk);
            check("t5_stall_hold", {7'd0, bus.out_last, bus.out_data}, {7'd0, (i == 4), 8'(i)});
            check("t5_stall_cmd", {bus.out_len, bus.out_cmd}, 16'h0433);
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        check("t5_done_valid", {15'd0, bus.out_valid}, 16'd0);
        check("t5_frame_cnt", bus.frame_cnt, 16'd4);

        // 6: garbage ignored, good frame, then reset mid-payload
        send(8'h00); send(8'hFF); send(8'h5A);
        errs_zero("t6_garbage");
        send(8'hA5); send(8'h07); send(8'h01); send(8'hC3); send(8'hC5);
        check("t6_beat", {7'd0, bus.out_last, bus.out_data}, 16'h1C3);
        check("t6_cmd", {8'd0, bus.out_cmd}, 16'h07);
        @(negedge clk);
        check("t6_frame_cnt", bus.frame_cnt, 16'd5);
        send(8'hA5); send(8'h07); send(8'h02); send(8'hAA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_rx_ready", {15'd0, bus.rx_data_ready}, 16'd1);
        check("t6_rst_outs", {6'd0, bus.out_valid, bus.out_last, bus.out_data}, 16'd0);
        check("t6_rst_hdr", {bus.out_cmd, bus.out_len}, 16'd0);
        check("t6_rst_cnt", bus.frame_cnt, 16'd0);
        errs_zero("t6_rst_errs");
        // Partial frame discarded: the 0xBB byte must not complete anything.
        send(8'hBB); send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
        check("t6_post_rst_beat", {6'd0, bus.out_valid, bus.out_last, bus.out_data}, 16'h300);
        @(negedge clk);
        check("t6_post_rst_cnt", bus.frame_cnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
